// File: rtl/nn_pkg.sv
// Shared widths and FSM state type for the neuron accumulator.
package nn_pkg;
   localparam int PROD_W = 17;
   localparam int OUT_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      ACT
   } state_t;
endpackage

// File: rtl/nn_saturate.sv
// Signed clamp from IN_W to OUT_W bits (IN_W must exceed OUT_W).
module nn_saturate #(
   parameter int IN_W  = 25,
   parameter int OUT_W = 24
) (
   input  logic signed [IN_W-1:0]  i_din,
   output logic signed [OUT_W-1:0] o_dout
);
   logic signed [IN_W-1:0] w_max;
   logic signed [IN_W-1:0] w_min;

   assign w_max = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   assign w_min = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   always_comb begin
      o_dout = i_din[OUT_W-1:0];
      if (i_din > w_max)
         o_dout = w_max[OUT_W-1:0];
      else if (i_din < w_min)
         o_dout = w_min[OUT_W-1:0];
   end
endmodule

// File: rtl/neuron_accumulator.sv
// Bias + product accumulator with rescale, saturation and activation.
// Define NEURON_ACC_RELU_EN to apply ReLU to the output.
module neuron_accumulator
   import nn_pkg::*;
#(
   parameter int N_INPUTS = 8,
   parameter int SHIFT    = 7,
   parameter int ACC_W    = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [PROD_W-1:0] bias_in,
   input  logic                     prod_valid,
   input  logic signed [PROD_W-1:0] prod_in,
   output logic                     prod_ready,
   output logic                     busy,
   output logic                     done,
   output logic signed [OUT_W-1:0]  neuron_out,
   output logic                     ovf
);
   state_t                   r_state;
   logic signed [ACC_W-1:0]  r_acc;
   logic [7:0]               r_count;
   logic signed [OUT_W-1:0]  r_out;
   logic                     r_done;
   logic                     r_ovf;

   logic signed [ACC_W:0]    w_sum;
   logic signed [ACC_W-1:0]  w_acc_sat;
   logic                     w_clip;
   logic signed [ACC_W-1:0]  w_shift;
   logic signed [OUT_W-1:0]  w_sat8;
   logic signed [OUT_W-1:0]  w_act;
   logic signed [ACC_W-1:0]  w_bias;
   logic                     w_last;

   assign w_bias = {{(ACC_W-PROD_W){bias_in[PROD_W-1]}}, bias_in};
   assign w_sum  = {r_acc[ACC_W-1], r_acc}
                 + {{(ACC_W+1-PROD_W){prod_in[PROD_W-1]}}, prod_in};
   assign w_clip = (w_sum != {w_acc_sat[ACC_W-1], w_acc_sat});
   assign w_shift = r_acc >>> SHIFT;
   assign w_last  = (r_count == 8'(N_INPUTS - 1));

   nn_saturate #(
      .IN_W  (ACC_W + 1),
      .OUT_W (ACC_W)
   ) u_sat_acc (
      .i_din  (w_sum),
      .o_dout (w_acc_sat)
   );

   nn_saturate #(
      .IN_W  (ACC_W),
      .OUT_W (OUT_W)
   ) u_sat_out (
      .i_din  (w_shift),
      .o_dout (w_sat8)
   );

`ifdef NEURON_ACC_RELU_EN
   assign w_act = w_sat8[OUT_W-1] ? '0 : w_sat8;
`else
   assign w_act = w_sat8;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_count <= '0;
         r_out   <= '0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_acc   <= w_bias;
                  r_count <= '0;
                  r_ovf   <= 1'b0;
                  r_state <= ACC;
               end
            end
            ACC: begin
               if (prod_valid) begin
                  r_acc   <= w_acc_sat;
                  r_count <= r_count + 8'd1;
                  if (w_clip)
                     r_ovf <= 1'b1;
                  if (w_last)
                     r_state <= ACT;
               end
            end
            ACT: begin
               r_out   <= w_act;
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // ready/busy are decoded straight from state so upstream sees them same-cycle
   assign prod_ready = (r_state == ACC);
   assign busy       = (r_state != IDLE);
   assign done       = r_done;
   assign neuron_out = r_out;
   assign ovf        = r_ovf;
endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed checks of neuron_accumulator: default build and an 18-bit acc variant.
module tb_neuron_accumulator;
   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start_a = 1'b0;
   logic               start_b = 1'b0;
   logic signed [16:0] bias_in = '0;
   logic               prod_valid = 1'b0;
   logic signed [16:0] prod_in = '0;

   logic       rdy_a, busy_a, done_a, ovf_a;
   logic [7:0] out_a;
   logic       rdy_b, busy_b, done_b, ovf_b;
   logic [7:0] out_b;

   bit         sel = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         n_done_a = 0;
   int         n0;

`ifdef NEURON_ACC_RELU_EN
   localparam logic [7:0] EXP_NEG16  = 8'h00;
   localparam logic [7:0] EXP_NEG1   = 8'h00;
   localparam logic [7:0] EXP_NEG128 = 8'h00;
`else
   localparam logic [7:0] EXP_NEG16  = 8'hF0;
   localparam logic [7:0] EXP_NEG1   = 8'hFF;
   localparam logic [7:0] EXP_NEG128 = 8'h80;
`endif

   always #5 clk = ~clk;

   neuron_accumulator u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .start      (start_a),
      .bias_in    (bias_in),
      .prod_valid (prod_valid),
      .prod_in    (prod_in),
      .prod_ready (rdy_a),
      .busy       (busy_a),
      .done       (done_a),
      .neuron_out (out_a),
      .ovf        (ovf_a)
   );

   neuron_accumulator #(
      .N_INPUTS (4),
      .ACC_W    (18)
   ) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .start      (start_b),
      .bias_in    (bias_in),
      .prod_valid (prod_valid),
      .prod_in    (prod_in),
      .prod_ready (rdy_b),
      .busy       (busy_b),
      .done       (done_b),
      .neuron_out (out_b),
      .ovf        (ovf_b)
   );

   wire       w_rdy  = sel ? rdy_b  : rdy_a;
   wire       w_busy = sel ? busy_b : busy_a;
   wire       w_done = sel ? done_b : done_a;
   wire       w_ovf  = sel ? ovf_b  : ovf_a;
   wire [7:0] w_out  = sel ? out_b  : out_a;

   always @(posedge clk)
      if (done_a) n_done_a++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic drive_start(input bit s, input logic v);
      if (s) start_b = v;
      else   start_a = v;
   endtask

   // Called at a negedge; returns at the negedge inside the done cycle.
   task automatic run_neuron(input string tag, input bit s,
                             input logic signed [16:0] b,
                             input logic signed [16:0] p,
                             input int n, input bit gap, input bit poke,
                             input logic [7:0] exp_out, input bit exp_ovf);
      int k;
      sel     = s;
      bias_in = b;
      drive_start(s, 1'b1);
      @(negedge clk);
      drive_start(s, 1'b0);
      chk({tag, "_busy"}, 32'(w_busy), 32'd1);
      chk({tag, "_ovfclr"}, 32'(w_ovf), 32'd0);
      for (int i = 0; i < n; i++) begin
         if (gap) begin
            prod_valid = 1'b0;
            @(negedge clk);
         end
         if (poke && i == 3) begin
            bias_in = 17'sh0ABCD;
            drive_start(s, 1'b1);
         end
         k = 0;
         while (!w_rdy && k < 8) begin
            @(negedge clk);
            k++;
         end
         if (!w_rdy) chk({tag, "_rdy_timeout"}, 32'd0, 32'd1);
         prod_valid = 1'b1;
         prod_in    = p;
         @(negedge clk);
         drive_start(s, 1'b0);
      end
      prod_valid = 1'b0;
      chk({tag, "_done_early"}, 32'(w_done), 32'd0);
      @(negedge clk);
      chk({tag, "_done"}, 32'(w_done), 32'd1);
      chk({tag, "_out"}, 32'(w_out), 32'(exp_out));
      chk({tag, "_ovf"}, 32'(w_ovf), 32'(exp_ovf));
      chk({tag, "_idle"}, 32'(w_busy), 32'd0);
   endtask

   initial begin
      #3;
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_rdy", 32'(rdy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_out", 32'(out_a), 32'd0);
      chk("rst_ovf_b", 32'(ovf_b), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      run_neuron("neg256", 1'b0, 17'sd0, -17'sd256, 8, 1'b0, 1'b0,
                 EXP_NEG16, 1'b0);
      @(negedge clk);
      run_neuron("trunc", 1'b0, -17'sd1, 17'sd0, 8, 1'b0, 1'b0,
                 EXP_NEG1, 1'b0);
      @(negedge clk);
      run_neuron("osat", 1'b0, 17'sd0, 17'sd16384, 8, 1'b0, 1'b0,
                 8'd127, 1'b0);
      @(negedge clk);
      n0 = n_done_a;
      run_neuron("gap", 1'b0, 17'sd640, 17'sd0, 8, 1'b1, 1'b0,
                 8'd5, 1'b0);
      run_neuron("b2b", 1'b0, 17'sd0, 17'sd128, 8, 1'b0, 1'b1,
                 8'd8, 1'b0);
      @(negedge clk);
      chk("b2b_done_low", 32'(done_a), 32'd0);
      chk("done_pulses", 32'(n_done_a - n0), 32'd2);

      run_neuron("accpos", 1'b1, 17'sd0, 17'sd65535, 4, 1'b0, 1'b0,
                 8'd127, 1'b1);
      repeat (3) @(negedge clk);
      chk("ovf_hold", 32'(ovf_b), 32'd1);
      chk("out_hold", 32'(out_b), 32'd127);
      run_neuron("accneg", 1'b1, 17'sd0, -17'sd65536, 4, 1'b0, 1'b0,
                 EXP_NEG128, 1'b1);
      @(negedge clk);

      sel     = 1'b0;
      bias_in = 17'sd0;
      start_a = 1'b1;
      @(negedge clk);
      start_a    = 1'b0;
      prod_valid = 1'b1;
      prod_in    = 17'sd1000;
      repeat (3) @(negedge clk);
      prod_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy_a), 32'd0);
      chk("mid_rst_rdy", 32'(rdy_a), 32'd0);
      chk("mid_rst_done", 32'(done_a), 32'd0);
      chk("mid_rst_out", 32'(out_a), 32'd0);
      chk("mid_rst_ovf_b", 32'(ovf_b), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_neuron("fresh", 1'b0, 17'sd0, 17'sd64, 8, 1'b0, 1'b0,
                 8'd4, 1'b0);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
endmodule
